// File: rtl/keypad_command_decoder.sv
// keypad_command_decoder: scans a 4x4 active-low matrix keypad, synchronises and
// debounces the row returns, and emits one registered strobe per accepted press
// together with start_on / start_off command pulses for the light controller.
module keypad_command_decoder #(
   parameter int         CLK_DIV      = 16,
   parameter int         DEBOUNCE_CNT = 3,
   parameter logic [3:0] KEY_ON       = 4'hA,
   parameter logic [3:0] KEY_OFF      = 4'hB
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       keypad,
   output logic       start_on,
   output logic       start_off,
   output logic [3:0] key_code,
   output logic       key_valid
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT);
   localparam logic [3:0]    ONE_HOT  = 4'b0001;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t          state, state_n;
   logic [1:0][3:0] sync_q;          // [0] first stage, [1] = rs
   logic [3:0]      rs;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [1:0]      col_idx, col_n;
   logic [3:0]      lrow, lrow_n;
   logic [CW-1:0]   dcnt, dcnt_n, dcnt_inc;
   logic [1:0]      row_idx;
   logic [3:0]      code_n;
   logic            accept, done;

   assign rs       = sync_q[1];
   assign tick     = (div_cnt == DIV_LAST);
   assign dcnt_inc = dcnt + CW'(1);
   assign col      = ~(ONE_HOT << col_idx);
   assign code_n   = {row_idx, col_idx};

   // two-flop synchroniser on the asynchronous row returns
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= {4'hF, 4'hF};
      else        sync_q <= {sync_q[0], row};
   end

   // scan tick divider, wraps at CLK_DIV-1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DW'(1);
   end

   // lowest-index low row of the latched pattern wins
   always_comb begin
      row_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!lrow[i]) row_idx = 2'(i);
   end

   // next-state logic; every change is gated by the scan tick
   always_comb begin
      state_n = state;
      col_n   = col_idx;
      lrow_n  = lrow;
      dcnt_n  = dcnt;
      accept  = 1'b0;
      done    = 1'b0;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (rs == 4'hF) col_n = col_idx + 2'd1;
               else begin
                  lrow_n  = rs;
                  dcnt_n  = '0;
                  state_n = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (rs == lrow) begin
                  if (dcnt_inc == DB_LAST) begin
                     state_n = PRESSED;
                     dcnt_n  = '0;
                     accept  = 1'b1;
                  end else dcnt_n = dcnt_inc;
               end else begin
                  state_n = SCAN;
                  col_n   = col_idx + 2'd1;
               end
            end
            PRESSED: begin
               // column held; only a full release matters here
               if (rs == 4'hF) begin
                  dcnt_n  = '0;
                  state_n = RELEASE;
               end
            end
            RELEASE: begin
               if (rs == 4'hF) begin
                  if (dcnt_inc == DB_LAST) begin
                     state_n = SCAN;
                     col_n   = col_idx + 2'd1;
                     dcnt_n  = '0;
                     done    = 1'b1;
                  end else dcnt_n = dcnt_inc;
               end else state_n = PRESSED;
            end
            default: state_n = SCAN;
         endcase
      end
   end

   // FSM and scan state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= SCAN;
         col_idx <= 2'd0;
         lrow    <= 4'hF;
         dcnt    <= '0;
      end else begin
         state   <= state_n;
         col_idx <= col_n;
         lrow    <= lrow_n;
         dcnt    <= dcnt_n;
      end
   end

   // registered strobe, command pulses and key status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         keypad    <= 1'b0;
         start_on  <= 1'b0;
         start_off <= 1'b0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         keypad    <= accept;
         start_on  <= accept && (code_n == KEY_ON);
         start_off <= accept && (code_n == KEY_OFF);
         if (accept) key_code <= code_n;
         if (accept)    key_valid <= 1'b1;
         else if (done) key_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_command_decoder.sv
// Directed bench for keypad_command_decoder with CLK_DIV=4, DEBOUNCE_CNT=3.
// A small keypad model pulls a row low while its column is driven; a force
// path lets the bench shape bounce precisely against the tick grid.
module tb_keypad_command_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic       keypad, start_on, start_off, key_valid;
   logic [3:0] key_code;

   logic       press_en = 1'b0;
   logic       force_en = 1'b0;
   logic [3:0] row_force = 4'hF;
   int         pr = 0, pc = 0;
   logic [3:0] sel_col;

   int n_chk = 0, n_pass = 0;
   int kp_cnt = 0, kv_cnt = 0, viol = 0;
   logic kp_q = 1'b0;

   keypad_command_decoder #(.CLK_DIV(4), .DEBOUNCE_CNT(3), .KEY_ON(4'hA), .KEY_OFF(4'hB)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col), .keypad(keypad),
      .start_on(start_on), .start_off(start_off), .key_code(key_code), .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   // keypad model: selected row goes low only while its column is driven
   always_comb begin
      row     = 4'hF;
      sel_col = ~(4'b0001 << pc);
      if (force_en) row = row_force;
      else if (press_en && col == sel_col) row = ~(4'b0001 << pr);
   end

   // pulse monitor
   always @(negedge clk) begin
      if (keypad) kp_cnt++;
      if (key_valid) kv_cnt++;
      if (keypad && kp_q) viol++;
      if (start_on && start_off) viol++;
      if ((start_on || start_off) && !keypad) viol++;
      kp_q = keypad;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   task automatic wait_kp(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(posedge clk); #1;
         if (keypad) ok = 1'b1;
      end
   endtask

   task automatic wait_kv_low(input int lim, output int n);
      n = -1;
      for (int i = 1; i <= lim && n < 0; i++) begin
         @(posedge clk); #1;
         if (!key_valid) n = i;
      end
   endtask

   // press and hold key (r,c); returns #1 after the strobe edge
   task automatic do_press(input string t, input int r, input int c,
                           input logic [3:0] ecode, input logic eon, input logic eoff);
      bit ok;
      pr = r; pc = c; press_en = 1'b1;
      wait_kp(200, ok);
      chk({t, "_kp_seen"}, ok, 1);
      chk({t, "_code"}, key_code, ecode);
      chk({t, "_on"}, start_on, eon);
      chk({t, "_off"}, start_off, eoff);
      chk({t, "_kv_rise"}, key_valid, 1);
   endtask

   // clean release: key_valid falls in bound and scan moves to next column
   task automatic do_release(input string t, input logic [3:0] ecol);
      int n;
      press_en = 1'b0;
      wait_kv_low(40, n);
      chk({t, "_rel_lat"}, (n >= 14 && n <= 19), 1);
      chk({t, "_resume"}, col, ecol);
   endtask

   initial begin
      int base, kvb, lowc;
      logic [3:0] ecol, prv;
      bit ok, found;

      // 1. reset and idle scan
      #23;
      chk("rst_col", col, 4'b1110);
      chk("rst_kp", keypad, 0);
      chk("rst_on_off", {start_on, start_off}, 0);
      chk("rst_code", key_code, 0);
      chk("rst_kv", key_valid, 0);
      @(negedge clk); reset = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(posedge clk); #1;
         ecol = ~(4'b0001 << ((j / 4) % 4));
         chk($sformatf("idle_col%0d", j), col, ecol);
      end
      chk("idle_no_kp", kp_cnt, 0);

      // 2. ON key (row 2, col 2)
      base = kp_cnt;
      do_press("on", 2, 2, 4'hA, 1, 0);
      repeat (40) @(posedge clk); #1;
      chk("on_kv_hold", key_valid, 1);
      chk("on_kp_once", kp_cnt - base, 1);
      do_release("on", 4'b0111);

      // 3. non-command key (row 1, col 1)
      base = kp_cnt;
      do_press("k5", 1, 1, 4'h5, 0, 0);
      repeat (20) @(posedge clk); #1;
      chk("k5_kp_once", kp_cnt - base, 1);
      do_release("k5", 4'b1011);

      // 4. press bounce: row low for one tick only
      base = kp_cnt; kvb = kv_cnt;
      force_en = 1'b1; row_force = 4'hF;
      found = 1'b0; prv = col;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (col == 4'b1110 && prv != 4'b1110) found = 1'b1;
         prv = col;
      end
      chk("pb_align", found, 1);
      row_force = 4'b1110;
      repeat (4) @(posedge clk); #1;
      chk("pb_col_held", col, 4'b1110);
      row_force = 4'hF;
      repeat (4) @(posedge clk); #1;
      chk("pb_col_next", col, 4'b1101);
      repeat (20) @(posedge clk); #1;
      force_en = 1'b0;
      chk("pb_no_kp", kp_cnt - base, 0);
      chk("pb_no_kv", kv_cnt - kvb, 0);

      // 5. OFF key with release bounce
      base = kp_cnt;
      do_press("off", 2, 3, 4'hB, 0, 1);
      repeat (8) @(posedge clk); #1;     // on a tick edge
      press_en = 1'b0;
      repeat (4) @(posedge clk); #1;     // first RELEASE tick just taken
      chk("rb_kv_in_rel", key_valid, 1);
      press_en = 1'b1;
      lowc = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (!key_valid) lowc++;
      end
      chk("rb_kv_stays", lowc, 0);
      chk("rb_kp_once", kp_cnt - base, 1);
      do_release("off", 4'b1110);

      // 6. reset mid-press, then one fresh strobe for the held key
      do_press("rp", 2, 2, 4'hA, 1, 0);
      repeat (6) @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("rp_kv", key_valid, 0);
      chk("rp_code", key_code, 0);
      chk("rp_col", col, 4'b1110);
      chk("rp_kp", keypad, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      base = kp_cnt;
      reset = 1'b1;
      wait_kp(200, ok);
      chk("rp_fresh_kp", ok, 1);
      chk("rp_fresh_code", key_code, 4'hA);
      repeat (10) @(posedge clk); #1;
      chk("rp_kp_once", kp_cnt - base, 1);
      do_release("rp", 4'b0111);

      chk("pulse_rules", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
